// File: rtl/glb_pkg.sv
// Shared types and sizing for the row-organised global buffer.
package glb_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 1024;
    localparam int LANES  = 16;

    // Row address width, kept at least one bit wide for a single-row buffer.
    function automatic int row_w(input int depth, input int lanes);
        return (depth / lanes > 1) ? $clog2(depth / lanes) : 1;
    endfunction

    localparam int ROWS  = DEPTH / LANES;
    localparam int ROW_W = row_w(DEPTH, LANES);
    localparam int IF_W  = LANES * DATA_W;

    typedef enum logic {IDLE, CLEAR} glb_state_e;

    // Lane i of a row lives at bits [i*DATA_W +: DATA_W] of the flat interface.
    typedef logic [LANES-1:0][DATA_W-1:0] glb_row_t;

endpackage

// File: rtl/glb_row_mem.sv
// ROWS x LANES x DATA_W storage: one lane-masked write port, one synchronous
// read-first read port. The array itself is never reset.
module glb_row_mem
    import glb_pkg::*;
(
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic             we_i,
    input  logic [ROW_W-1:0] wr_row_i,
    input  logic [LANES-1:0] wr_mask_i,
    input  glb_row_t         wr_data_i,
    input  logic             re_i,
    input  logic [ROW_W-1:0] rd_row_i,
    output glb_row_t         rd_data_o
);

    glb_row_t mem_q [ROWS];
    glb_row_t rd_data_q;

    // Masked row write; unmasked lanes keep their contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_mask_i[l]) mem_q[wr_row_i][l] <= wr_data_i[l];
            end
        end
    end

    // Read register: samples the pre-write row (read-first) and holds when idle.
    always_ff @(posedge clk_i) begin
        if (!nrst_i)   rd_data_q <= '0;
        else if (re_i) rd_data_q <= mem_q[rd_row_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/glb_banked_buffer.sv
// Global buffer top: clear FSM, clear-vs-user write mux, read response
// register and the write/read handshakes.
module glb_banked_buffer
    import glb_pkg::*;
(
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [ROW_W-1:0] wr_row_i,
    input  logic [IF_W-1:0]  wr_data_i,
    input  logic [LANES-1:0] wr_mask_i,
    input  logic             rd_req_valid_i,
    output logic             rd_req_ready_o,
    input  logic [ROW_W-1:0] rd_row_i,
    output logic             rd_rsp_valid_o,
    input  logic             rd_rsp_ready_i,
    output logic [IF_W-1:0]  rd_rsp_data_o,
    input  logic             clr_start_i,
    output logic             busy_o,
    output logic             clr_done_o
);

    glb_state_e       state_q, state_d;
    logic [ROW_W-1:0] cnt_q, cnt_d;
    logic             clr_done_q, clr_done_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic             idle;
    logic             wr_acc;
    logic             rd_acc;
    logic             mem_we;
    logic [ROW_W-1:0] mem_wr_row;
    logic [LANES-1:0] mem_wr_mask;
    glb_row_t         mem_wr_data;
    glb_row_t         mem_rd_data;

    assign idle           = (state_q == IDLE);
    assign wr_ready_o     = idle;
    assign rd_req_ready_o = idle && (!rsp_valid_q || rd_rsp_ready_i);
    assign wr_acc         = wr_valid_i && wr_ready_o;
    assign rd_acc         = rd_req_valid_i && rd_req_ready_o;

    // Clear FSM: one row per cycle, done pulse on the first IDLE cycle after.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_start_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ROW_W'(ROWS - 1)) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response valid: set on accept, cleared on a consume with no new accept.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        if (rd_acc)              rsp_valid_d = 1'b1;
        else if (rd_rsp_ready_i) rsp_valid_d = 1'b0;
    end

    // Write mux: clear owns the port in CLEAR; nothing is written under reset
    // so an aborted clear leaves the current row untouched.
    always_comb begin
        mem_we      = 1'b0;
        mem_wr_row  = wr_row_i;
        mem_wr_mask = wr_mask_i;
        mem_wr_data = wr_data_i;
        if (!idle) begin
            mem_we      = nrst_i;
            mem_wr_row  = cnt_q;
            mem_wr_mask = '1;
            mem_wr_data = '0;
        end else begin
            mem_we = wr_acc && nrst_i;
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            clr_done_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clr_done_q  <= clr_done_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    glb_row_mem u_mem (
        .clk_i     (clk_i),
        .nrst_i    (nrst_i),
        .we_i      (mem_we),
        .wr_row_i  (mem_wr_row),
        .wr_mask_i (mem_wr_mask),
        .wr_data_i (mem_wr_data),
        .re_i      (rd_acc),
        .rd_row_i  (rd_row_i),
        .rd_data_o (mem_rd_data)
    );

    assign rd_rsp_valid_o = rsp_valid_q;
    assign rd_rsp_data_o  = mem_rd_data;
    assign busy_o         = !idle;
    assign clr_done_o     = clr_done_q;

endmodule

// File: tb/tb_glb_banked_buffer.sv
// Directed bench for glb_banked_buffer with a response scoreboard.
module tb_glb_banked_buffer;
    import glb_pkg::*;

    logic             clk = 1'b0;
    logic             nrst;
    logic             wr_valid;
    logic             wr_ready;
    logic [ROW_W-1:0] wr_row;
    logic [IF_W-1:0]  wr_data;
    logic [LANES-1:0] wr_mask;
    logic             rd_req_valid;
    logic             rd_req_ready;
    logic [ROW_W-1:0] rd_row;
    logic             rd_rsp_valid;
    logic             rd_rsp_ready;
    logic [IF_W-1:0]  rd_rsp_data;
    logic             clr_start;
    logic             busy;
    logic             clr_done;

    int n_chk  = 0;
    int n_fail = 0;
    logic [IF_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    glb_banked_buffer dut (
        .clk_i          (clk),
        .nrst_i         (nrst),
        .wr_valid_i     (wr_valid),
        .wr_ready_o     (wr_ready),
        .wr_row_i       (wr_row),
        .wr_data_i      (wr_data),
        .wr_mask_i      (wr_mask),
        .rd_req_valid_i (rd_req_valid),
        .rd_req_ready_o (rd_req_ready),
        .rd_row_i       (rd_row),
        .rd_rsp_valid_o (rd_rsp_valid),
        .rd_rsp_ready_i (rd_rsp_ready),
        .rd_rsp_data_o  (rd_rsp_data),
        .clr_start_i    (clr_start),
        .busy_o         (busy),
        .clr_done_o     (clr_done)
    );

    function automatic logic [IF_W-1:0] fill(input logic [7:0] b);
        logic [IF_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = b;
        return r;
    endfunction

    function automatic logic [IF_W-1:0] rowpat(input logic [7:0] base);
        logic [IF_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = base + 8'(i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [IF_W-1:0] got, input logic [IF_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ROW_W-1:0] row, input logic [IF_W-1:0] d, input logic [LANES-1:0] m);
        chk("wr_ready", IF_W'(wr_ready), IF_W'(1));
        wr_valid = 1'b1; wr_row = row; wr_data = d; wr_mask = m;
        tick();
        wr_valid = 1'b0; wr_mask = '0;
    endtask

    task automatic do_read(input logic [ROW_W-1:0] row, input logic [IF_W-1:0] exp);
        int   n;
        logic acc;
        rd_req_valid = 1'b1; rd_row = row;
        exp_q.push_back(exp);
        n = 0; acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = rd_req_ready;
            tick();
            n++;
        end
        rd_req_valid = 1'b0;
        chk("rd_accept", IF_W'(acc), IF_W'(1));
        chk("rd_latency", IF_W'(rd_rsp_valid), IF_W'(1));
    endtask

    // Monitor: every consumed response is checked against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (nrst && rd_rsp_valid && rd_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rsp_unexpected: got %h expected no response", rd_rsp_data);
                end else begin
                    chk("rsp_data", rd_rsp_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IF_W-1:0] exp5;
        int   n;
        logic bad;

        nrst = 1'b0; wr_valid = 1'b0; wr_row = '0; wr_data = '0; wr_mask = '0;
        rd_req_valid = 1'b0; rd_row = '0; rd_rsp_ready = 1'b1; clr_start = 1'b0;

        // 1. reset
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        chk("rst_rsp_valid", IF_W'(rd_rsp_valid), IF_W'(0));
        chk("rst_rsp_data", rd_rsp_data, '0);
        chk("rst_busy", IF_W'(busy), IF_W'(0));
        chk("rst_clr_done", IF_W'(clr_done), IF_W'(0));
        chk("rst_wr_ready", IF_W'(wr_ready), IF_W'(1));
        chk("rst_rd_req_ready", IF_W'(rd_req_ready), IF_W'(1));

        // 2. masked write
        do_write(5, rowpat(8'h01), 16'hFFFF);
        do_write(5, fill(8'hAA), 16'h00F0);
        exp5 = rowpat(8'h01);
        for (int i = 4; i < 8; i++) exp5[i*DATA_W +: DATA_W] = 8'hAA;
        do_read(5, exp5);
        do_write(5, fill(8'hEE), 16'h0000);
        do_read(5, exp5);

        // 3. backpressure
        for (int r = 0; r < 4; r++) do_write(ROW_W'(r), rowpat(8'h40 + 8'(r*16)), 16'hFFFF);
        rd_rsp_ready = 1'b0;
        rd_req_valid = 1'b1; rd_row = 0;
        exp_q.push_back(rowpat(8'h40));
        @(negedge clk);
        chk("bp_first_ready", IF_W'(rd_req_ready), IF_W'(1));
        tick();
        chk("bp_first_valid", IF_W'(rd_rsp_valid), IF_W'(1));
        rd_row = 1;
        exp_q.push_back(rowpat(8'h50));
        for (int k = 0; k < 3; k++) begin
            chk("bp_req_ready", IF_W'(rd_req_ready), IF_W'(0));
            chk("bp_hold", rd_rsp_data, rowpat(8'h40));
            tick();
        end
        rd_rsp_ready = 1'b1;
        tick();
        do_read(2, rowpat(8'h60));
        do_read(3, rowpat(8'h70));

        // 4. read-first hazard
        do_write(9, fill(8'h11), 16'hFFFF);
        wr_valid = 1'b1; wr_row = 9; wr_data = fill(8'h55); wr_mask = 16'hFFFF;
        rd_req_valid = 1'b1; rd_row = 9;
        exp_q.push_back(fill(8'h11));
        @(negedge clk);
        chk("hz_ready", IF_W'(rd_req_ready & wr_ready), IF_W'(1));
        tick();
        wr_valid = 1'b0; rd_req_valid = 1'b0;
        do_read(9, fill(8'h55));

        // 5. clear with a same-cycle write and read
        wr_valid = 1'b1; wr_row = 63; wr_data = fill(8'h99); wr_mask = 16'hFFFF;
        rd_req_valid = 1'b1; rd_row = 3; clr_start = 1'b1;
        exp_q.push_back(rowpat(8'h70));
        @(negedge clk);
        chk("clr_same_ready", IF_W'(rd_req_ready & wr_ready), IF_W'(1));
        tick();
        wr_valid = 1'b0; rd_req_valid = 1'b0; clr_start = 1'b0;
        chk("clr_rsp_valid", IF_W'(rd_rsp_valid), IF_W'(1));
        n = 0; bad = 1'b0;
        while (busy && n < 200) begin
            if (wr_ready || rd_req_ready || clr_done) bad = 1'b1;
            n++;
            tick();
        end
        chk("clr_blocked", IF_W'(bad), IF_W'(0));
        chk("clr_cycles", IF_W'(n), IF_W'(ROWS));
        chk("clr_done_pulse", IF_W'(clr_done), IF_W'(1));
        chk("clr_wr_ready", IF_W'(wr_ready), IF_W'(1));
        tick();
        chk("clr_done_once", IF_W'(clr_done), IF_W'(0));
        do_read(0, '0);
        do_read(63, '0);
        do_read(9, '0);

        // 6. reset mid-clear
        for (int r = 0; r < 12; r++) do_write(ROW_W'(r), fill(8'h33), 16'hFFFF);
        do_write(20, fill(8'h77), 16'hFFFF);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (10) tick();
        chk("mid_busy", IF_W'(busy), IF_W'(1));
        nrst = 1'b0;
        tick();
        chk("mid_rst_busy", IF_W'(busy), IF_W'(0));
        chk("mid_rst_done", IF_W'(clr_done), IF_W'(0));
        chk("mid_rst_wr_ready", IF_W'(wr_ready), IF_W'(1));
        nrst = 1'b1;
        for (int r = 0; r < 10; r++) do_read(ROW_W'(r), '0);
        do_read(11, fill(8'h33));
        do_read(20, fill(8'h77));

        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain", IF_W'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
